ttl74138_scan: RTL
==================

// Module: ttl74138_scan
// PURPOSE
//  Parametrised, clocked successor of the 3-to-8 active-low decoder. Decodes an
//  ADDR_W-bit address to 2**ADDR_W one-cold (or one-hot) outputs behind the
//  same G1 / G2A_n / G2B_n enable gating. Adds scan modes where an internal
//  address counter steps up, down or ping-pong at a prescaled rate.
//  Sits between the board switches and the LED bank. Used for decoder labs and
//  for LED chaser demos.
// PARAMETERS
//  ADDR_W      3     address width; output count OUT_N = 2**ADDR_W (ADDR_W >= 1)
//  DIV         1     prescaler period in clk cycles per scan step (DIV >= 1)
//  ACTIVE_LOW  1     1: selected output 0, others 1; 0: selected 1, others 0
// PORTS
//  clk      in   1        system clock, all state on rising edge
//  rst      in   1        synchronous reset, active-high
//  g1       in   1        enable, active-high
//  g2a_n    in   1        enable, active-low
//  g2b_n    in   1        enable, active-low
//  mode     in   2        00 direct, 01 scan up, 10 scan down, 11 ping-pong
//  a        in   ADDR_W   address, used in direct mode only
//  y        out  OUT_N    decoded outputs, registered
//  addr_q   out  ADDR_W   current decoded / scan address, registered
//  tick     out  1        one-cycle pulse on each scan step
// BEHAVIOUR
//  - Synchronous reset, active-high. Reset dominates all other inputs.
//  - Values after reset:
//      y       = all inactive (all 1s if ACTIVE_LOW, else 0)
//      addr_q  = 0
//      tick    = 0
//      prescaler count = 0
//      direction = up
//  - Enable: en = g1 & ~g2a_n & ~g2b_n, sampled every cycle.
//  - en=0:
//      y goes all inactive on the next edge.
//      addr_q, direction and prescaler hold.
//      tick = 0.
//  - Direct mode (00), en=1:
//      addr_q <= a.
//      y <= decode(a). Latency is 1 clk from a to y.
//      Prescaler is held at 0 and tick = 0.
//  - Scan modes, en=1:
//      Prescaler counts 0..DIV-1.
//      At DIV-1 the count wraps to 0, tick=1 for that cycle, and addr_q steps.
//      With DIV=1, tick is high every enabled cycle.
//  - Scan up (01):   MAX wraps to 0.
//  - Scan down (10): 0 wraps to MAX.
//  - Ping-pong (11):
//      Moving up at MAX: addr_q <= MAX-1 and direction <= down.
//      Moving down at 0: addr_q <= 1 and direction <= up.
//      Endpoints are never repeated.
//      With ADDR_W=1 the sequence is 0,1,0,1.
//  - Modes 01 and 10 also load direction (up / down), so later ping-pong
//    entry continues from that direction.
//  - Decode in scan modes: y is decoded from the new addr_q value, so y and
//    addr_q change on the same edge.
//  - Mode change (mode differs from previous-cycle mode):
//      Prescaler clears to 0.
//      addr_q keeps its value, so scan resumes from the last direct address.
//      The first step occurs DIV enabled cycles later.
//  - Enable gating does not reset the scan: after en returns, scanning
//    resumes from the held count.
//  - Width rules:
//      Prescaler width is $clog2(DIV), minimum 1.
//      addr_q arithmetic is modulo 2**ADDR_W.
//  - Reset mid-scan: the next cycle is identical to the reset values above.
//    Scanning restarts at 0, direction up.
// TESTING
//  1. Direct, ADDR_W=3, ACTIVE_LOW=1, en=1: sweep a=0..7
//     -> y=8'hFE,FD,FB,...,7F one cycle after each a.
//  2. Gating:
//     a. g1=0, or g2a_n=1, or g2b_n=1 with a=5 -> y=8'hFF next cycle.
//     b. Restore enable -> y=8'hDF.
//  3. Scan up, DIV=4 from addr_q=6:
//     a. tick every 4th cycle.
//     b. addr_q 6,7,0,1.
//     c. y 8'hBF,7F,FE,FD.
//  4. Ping-pong, DIV=1, from 0:
//     a. addr_q 0,1,...,7,6,...,0,1.
//     b. 7 and 0 are each held exactly one cycle at the turns.
//  5. Scan down, DIV=2, en dropped for 3 cycles mid-count:
//     a. y=8'hFF during the gap; addr_q and count are frozen.
//     b. Stepping resumes without a lost or extra step.
//  6. rst asserted mid ping-pong, moving down at addr_q=3
//     -> next cycle addr_q=0, y=8'hFF, tick=0.
//     After rst releases in mode 11, the first step goes to 1 (direction up).

Source files
------------

// File: rtl/ttl74138_scan.sv
// Clocked, parametrised 74138-style decoder with G1/G2A_n/G2B_n gating and
// an internal scan counter (up, down, ping-pong) stepped by a prescaler.
module ttl74138_scan #(
    parameter int ADDR_W     = 3,
    parameter int DIV        = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_g1,
    input  logic                   i_g2a_n,
    input  logic                   i_g2b_n,
    input  logic [1:0]             i_mode,
    input  logic [ADDR_W-1:0]      i_a,
    output logic [2**ADDR_W-1:0]   o_y,
    output logic [ADDR_W-1:0]      o_addr_q,
    output logic                   o_tick
);
    localparam int OUT_N = 2**ADDR_W;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     P_LAST = PW'(DIV - 1);
    localparam logic [ADDR_W-1:0] A_MAX  = '1;
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic              AL     = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_PING   = 2'b11
    } mode_t;

    logic [OUT_N-1:0]  r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_tick;
    logic [PW-1:0]     r_cnt;
    logic              r_dir_up;
    mode_t             r_mode_prev;

    mode_t             w_mode;
    logic              w_en;
    logic              w_mode_chg;
    logic              w_step;
    logic              w_dir_cur;
    logic              w_dir_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [OUT_N-1:0]  w_dec;
    logic [OUT_N-1:0]  w_inact;

    assign w_mode     = mode_t'(i_mode);
    assign w_en       = i_g1 & ~i_g2a_n & ~i_g2b_n;
    assign w_mode_chg = (w_mode != r_mode_prev);
    assign w_inact    = {OUT_N{AL}};

    // A step happens only on the prescaler's last count, never on the cycle
    // a new mode is first seen (that cycle restarts the count instead).
    assign w_step = w_en && (w_mode != M_DIRECT) && !w_mode_chg && (r_cnt == P_LAST);

    always_comb begin
        w_dir_cur = r_dir_up;
        if (w_mode == M_UP)
            w_dir_cur = 1'b1;
        else if (w_mode == M_DOWN)
            w_dir_cur = 1'b0;
    end

    always_comb begin
        w_addr_nxt = r_addr;
        w_dir_nxt  = w_dir_cur;
        if (w_step) begin
            case (w_mode)
                M_UP:   w_addr_nxt = r_addr + A_ONE;
                M_DOWN: w_addr_nxt = r_addr - A_ONE;
                M_PING: begin
                    if (w_dir_cur) begin
                        if (r_addr == A_MAX) begin
                            w_addr_nxt = A_MAX - A_ONE;
                            w_dir_nxt  = 1'b0;
                        end else begin
                            w_addr_nxt = r_addr + A_ONE;
                        end
                    end else begin
                        if (r_addr == '0) begin
                            w_addr_nxt = A_ONE;
                            w_dir_nxt  = 1'b1;
                        end else begin
                            w_addr_nxt = r_addr - A_ONE;
                        end
                    end
                end
                default: w_addr_nxt = r_addr;
            endcase
        end
    end

    // Decode the address that addr_q will take, so y and addr_q move together.
    assign w_addr_sel = (w_mode == M_DIRECT) ? i_a : w_addr_nxt;

    for (genvar i = 0; i < OUT_N; i++) begin : g_dec
        assign w_dec[i] = ((w_addr_sel == ADDR_W'(i)) ? 1'b1 : 1'b0) ^ AL;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y         <= w_inact;
            r_addr      <= '0;
            r_tick      <= 1'b0;
            r_cnt       <= '0;
            r_dir_up    <= 1'b1;
            r_mode_prev <= M_DIRECT;
        end else begin
            r_mode_prev <= w_mode;
            if (!w_en) begin
                r_y    <= w_inact;
                r_tick <= 1'b0;
            end else if (w_mode == M_DIRECT) begin
                r_addr <= i_a;
                r_y    <= w_dec;
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else begin
                r_addr   <= w_addr_nxt;
                r_dir_up <= w_dir_nxt;
                r_y      <= w_dec;
                r_tick   <= w_step;
                r_cnt    <= (w_mode_chg || w_step) ? '0 : r_cnt + PW'(1);
            end
        end
    end

    assign o_y      = r_y;
    assign o_addr_q = r_addr;
    assign o_tick   = r_tick;
endmodule
